// File: rtl/cp0_exception_controller_pkg.sv
// CP0 register layouts, {rd,sel} addresses and ExcCode values shared by the
// exception controller, its timer and the pipeline.
package coprocessor0_params;

  // CP0 register addresses as {rd[4:0], sel[2:0]}
  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [8:0] rsvd_hi;   // 31:23
    logic       bev;       // 22
    logic [5:0] rsvd_mid;  // 21:16
    logic [7:0] im;        // 15:8
    logic [5:0] rsvd_lo;   // 7:2
    logic       exl;       // 1
    logic       ie;        // 0
  } status_t;

  typedef struct packed {
    logic        bd;       // 31
    logic        ti;       // 30
    logic [13:0] rsvd_hi;  // 29:16
    logic [7:0]  ip;       // 15:8
    logic        rsvd_mid; // 7
    logic [4:0]  exc_code; // 6:2
    logic [1:0]  rsvd_lo;  // 1:0
  } cause_t;

  typedef struct packed { logic [31:0] value; } epc_t;
  typedef struct packed { logic [31:0] value; } badvaddr_t;
  typedef struct packed { logic [31:0] value; } count_t;
  typedef struct packed { logic [31:0] value; } compare_t;

endpackage

// File: rtl/cp0_exception_controller_if.sv
// Writeback-stage / fetch-redirect bundle between the pipeline (master) and
// the CP0 exception controller (slave).
interface cp0_exception_controller_if;
  logic        wb_valid;
  logic        wb_exception;
  logic [4:0]  wb_exc_code;
  logic        wb_in_delay_slot;
  logic [31:0] wb_pc;
  logic        wb_badvaddr_valid;
  logic [31:0] wb_badvaddr;
  logic        wb_eret;
  logic        wb_mtc0;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [5:0]  hw_int;
  logic        int_pending;
  logic        flush;
  logic [31:0] flush_target;
  logic        status_exl;

  modport master (
    output wb_valid, wb_exception, wb_exc_code, wb_in_delay_slot, wb_pc,
           wb_badvaddr_valid, wb_badvaddr, wb_eret, wb_mtc0, cp0_addr,
           cp0_wdata, hw_int,
    input  cp0_rdata, int_pending, flush, flush_target, status_exl
  );

  modport slave (
    input  wb_valid, wb_exception, wb_exc_code, wb_in_delay_slot, wb_pc,
           wb_badvaddr_valid, wb_badvaddr, wb_eret, wb_mtc0, cp0_addr,
           cp0_wdata, hw_int,
    output cp0_rdata, int_pending, flush, flush_target, status_exl
  );
endinterface

// File: rtl/cp0_exception_controller_timer.sv
// Count/Compare timer: prescaler, Count, Compare and the sticky timer
// interrupt flag. Write strobes come from the controller's mtc0 decode.
module cp0_timer
  import coprocessor0_params::*;
#(
  parameter int COUNT_DIVIDE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output count_t      count,
  output compare_t    compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIVIDE > 1) ? $clog2(COUNT_DIVIDE) : 1;

  logic [DIV_W-1:0] div_reg;
  count_t           count_reg;
  compare_t         compare_reg;
  logic             ti_reg;
  logic             tick;
  logic [31:0]      count_next;
  logic             count_change;

  assign tick = (div_reg == DIV_W'(COUNT_DIVIDE - 1));

  // Next Count value: a software write beats the prescaler increment
  always_comb begin
    count_next   = count_reg.value;
    count_change = 1'b0;
    if (count_we) begin
      count_next   = wdata;
      count_change = 1'b1;
    end else if (tick) begin
      count_next   = count_reg.value + 32'd1;
      count_change = 1'b1;
    end
  end

  // Prescaler, Count, Compare and TI; a Compare write clears TI even on a match
  always_ff @(posedge clock) begin
    if (reset) begin
      div_reg     <= '0;
      count_reg   <= '0;
      compare_reg <= '0;
      ti_reg      <= 1'b0;
    end else begin
      div_reg         <= (count_we || tick) ? '0 : div_reg + 1'b1;
      count_reg.value <= count_next;
      if (compare_we) begin
        compare_reg.value <= wdata;
        ti_reg            <= 1'b0;
      end else if (count_change && (count_next == compare_reg.value)) begin
        ti_reg <= 1'b1;
      end
    end
  end

  assign count   = count_reg;
  assign compare = compare_reg;
  assign ti      = ti_reg;

endmodule

// File: rtl/cp0_exception_controller.sv
// CP0 exception controller: commits interrupts, exceptions, eret and mtc0 from
// writeback, serves mfc0 reads, and issues a registered flush/redirect.
module cp0_exception_controller
  import coprocessor0_params::*;
#(
  parameter logic [31:0] BEV_VECTOR    = 32'hBFC00380,
  parameter logic [31:0] NORMAL_VECTOR = 32'h80000180,
  parameter int          COUNT_DIVIDE  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  cp0_exception_controller_if.slave   bus
);

  logic [7:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic [4:0]  exc_code_reg;
  logic [1:0]  ip_sw_reg;
  logic [5:0]  ip_hw_reg;
  epc_t        epc_reg;
  badvaddr_t   badvaddr_reg;
  logic        flush_reg;
  logic [31:0] flush_target_reg;

  count_t      count;
  compare_t    compare;
  logic        ti;
  status_t     status;
  cause_t      cause;
  logic [7:0]  ip;
  logic        int_pending;
  logic        take_int, take_exc, take_eret, take_mtc0;
  logic [4:0]  event_code;

  assign ip          = {ip_hw_reg[5] | ti, ip_hw_reg[4:0], ip_sw_reg};
  assign int_pending = ie_reg & ~exl_reg & (|(ip & im_reg));

  // Only the highest-priority event in a retiring slot acts
  assign take_int   = bus.wb_valid & int_pending;
  assign take_exc   = bus.wb_valid & ~int_pending & bus.wb_exception;
  assign take_eret  = bus.wb_valid & ~int_pending & ~bus.wb_exception & bus.wb_eret;
  assign take_mtc0  = bus.wb_valid & ~int_pending & ~bus.wb_exception & ~bus.wb_eret
                      & bus.wb_mtc0;
  assign event_code = take_int ? EXC_INT : bus.wb_exc_code;

  cp0_timer #(.COUNT_DIVIDE(COUNT_DIVIDE)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .count_we   (take_mtc0 && (bus.cp0_addr == CP0_COUNT)),
    .compare_we (take_mtc0 && (bus.cp0_addr == CP0_COMPARE)),
    .wdata      (bus.cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Assemble architectural Status/Cause views from the stored fields
  always_comb begin
    status        = '0;
    status.bev    = 1'b1;
    status.im     = im_reg;
    status.exl    = exl_reg;
    status.ie     = ie_reg;
    cause          = '0;
    cause.bd       = bd_reg;
    cause.ti       = ti;
    cause.ip       = ip;
    cause.exc_code = exc_code_reg;
  end

  // mfc0 read mux; unmapped addresses read as zero
  always_comb begin
    bus.cp0_rdata = 32'd0;
    case (bus.cp0_addr)
      CP0_BADVADDR: bus.cp0_rdata = badvaddr_reg.value;
      CP0_COUNT:    bus.cp0_rdata = count.value;
      CP0_COMPARE:  bus.cp0_rdata = compare.value;
      CP0_STATUS:   bus.cp0_rdata = status;
      CP0_CAUSE:    bus.cp0_rdata = cause;
      CP0_EPC:      bus.cp0_rdata = epc_reg.value;
      default:      bus.cp0_rdata = 32'd0;
    endcase
  end

  // Commit sequencing, interrupt line sampling and registered flush/redirect
  always_ff @(posedge clock) begin
    if (reset) begin
      im_reg           <= '0;
      exl_reg          <= 1'b0;
      ie_reg           <= 1'b0;
      bd_reg           <= 1'b0;
      exc_code_reg     <= '0;
      ip_sw_reg        <= '0;
      ip_hw_reg        <= '0;
      epc_reg          <= '0;
      badvaddr_reg     <= '0;
      flush_reg        <= 1'b0;
      flush_target_reg <= '0;
    end else begin
      ip_hw_reg <= bus.hw_int;
      flush_reg <= take_int | take_exc | take_eret;
      if (take_int || take_exc) begin
        // A nested exception keeps the EPC/BD of the original one
        if (!exl_reg) begin
          epc_reg.value <= bus.wb_in_delay_slot ? bus.wb_pc - 32'd4 : bus.wb_pc;
          bd_reg        <= bus.wb_in_delay_slot;
        end
        exl_reg      <= 1'b1;
        exc_code_reg <= event_code;
        if (take_exc && bus.wb_badvaddr_valid) begin
          badvaddr_reg.value <= bus.wb_badvaddr;
        end
        flush_target_reg <= status.bev ? BEV_VECTOR : NORMAL_VECTOR;
      end else if (take_eret) begin
        exl_reg          <= 1'b0;
        flush_target_reg <= epc_reg.value;
      end else if (take_mtc0) begin
        case (bus.cp0_addr)
          CP0_STATUS: begin
            im_reg  <= bus.cp0_wdata[15:8];
            exl_reg <= bus.cp0_wdata[1];
            ie_reg  <= bus.cp0_wdata[0];
          end
          CP0_CAUSE: ip_sw_reg     <= bus.cp0_wdata[9:8];
          CP0_EPC:   epc_reg.value <= bus.cp0_wdata;
          default:   ;
        endcase
      end
    end
  end

  assign bus.int_pending  = int_pending;
  assign bus.flush        = flush_reg;
  assign bus.flush_target = flush_target_reg;
  assign bus.status_exl   = exl_reg;

endmodule

// File: tb/tb_cp0_exception_controller.sv
// Directed bench for the CP0 exception controller: a write/read-back vector
// table plus hand-written commit, timer, priority, wrap and reset sequences.
module tb_cp0_exception_controller;
  import coprocessor0_params::*;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  cp0_exception_controller_if bus ();

  cp0_exception_controller #(
    .BEV_VECTOR    (32'hBFC00380),
    .NORMAL_VECTOR (32'h80000180),
    .COUNT_DIVIDE  (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [7:0] addr, input logic [31:0] exp);
    bus.cp0_addr = addr;
    #1;
    check(name, bus.cp0_rdata, exp);
  endtask

  task automatic idle_inputs();
    bus.wb_valid          = 1'b0;
    bus.wb_exception      = 1'b0;
    bus.wb_exc_code       = 5'd0;
    bus.wb_in_delay_slot  = 1'b0;
    bus.wb_pc             = 32'd0;
    bus.wb_badvaddr_valid = 1'b0;
    bus.wb_badvaddr       = 32'd0;
    bus.wb_eret           = 1'b0;
    bus.wb_mtc0           = 1'b0;
    bus.cp0_wdata         = 32'd0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    bus.wb_valid  = 1'b1;
    bus.wb_mtc0   = 1'b1;
    bus.cp0_addr  = addr;
    bus.cp0_wdata = data;
    step();
    idle_inputs();
  endtask

  task automatic commit_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                            input logic bv, input logic [31:0] bva);
    bus.wb_valid          = 1'b1;
    bus.wb_exception      = 1'b1;
    bus.wb_exc_code       = code;
    bus.wb_pc             = pc;
    bus.wb_in_delay_slot  = ds;
    bus.wb_badvaddr_valid = bv;
    bus.wb_badvaddr       = bva;
    step();
    idle_inputs();
  endtask

  task automatic commit_plain(input logic [31:0] pc);
    bus.wb_valid = 1'b1;
    bus.wb_pc    = pc;
    step();
    idle_inputs();
  endtask

  task automatic commit_eret();
    bus.wb_valid = 1'b1;
    bus.wb_eret  = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.hw_int   = 6'd0;
    bus.cp0_addr = 8'd0;
    idle_inputs();

    vecs[0] = '{"status_all",    CP0_STATUS,   32'hFFFFFFFF, 32'h0040FF03};
    vecs[1] = '{"status_zero",   CP0_STATUS,   32'h00000000, 32'h00400000};
    vecs[2] = '{"cause_all",     CP0_CAUSE,    32'hFFFFFFFF, 32'h00000300};
    vecs[3] = '{"cause_zero",    CP0_CAUSE,    32'h00000000, 32'h00000000};
    vecs[4] = '{"epc_word",      CP0_EPC,      32'h12345678, 32'h12345678};
    vecs[5] = '{"badvaddr_ro",   CP0_BADVADDR, 32'hDEADBEEF, 32'h00000000};
    vecs[6] = '{"compare_word",  CP0_COMPARE,  32'h00000055, 32'h00000055};
    vecs[7] = '{"count_word",    CP0_COUNT,    32'h00000100, 32'h00000100};
    vecs[8] = '{"unmapped_10_0", 8'h50,        32'hFFFFFFFF, 32'h00000000};
    vecs[9] = '{"unmapped_12_1", 8'h61,        32'hFFFFFFFF, 32'h00000000};

    // Reset state
    repeat (3) step();
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_flush_target", bus.flush_target, 32'd0);
    check("rst_exl", {31'd0, bus.status_exl}, 32'd0);
    rd_check("rst_status", CP0_STATUS, 32'h00400000);
    rd_check("rst_cause", CP0_CAUSE, 32'h00000000);
    rd_check("rst_count", CP0_COUNT, 32'h00000000);
    reset = 1'b0;
    step();
    $display("reset sequence checked");

    // Write / read-back table
    for (int i = 0; i < 10; i++) begin
      mtc0(vecs[i].addr, vecs[i].wdata);
      check({vecs[i].name, "_flush"}, {31'd0, bus.flush}, 32'd0);
      rd_check(vecs[i].name, vecs[i].addr, vecs[i].exp_rdata);
      $display("vec %0d %s addr=%02h wdata=%08h rdata=%08h", i, vecs[i].name,
               vecs[i].addr, vecs[i].wdata, bus.cp0_rdata);
    end
    rd_check("status_after_unmapped", CP0_STATUS, 32'h00400000);

    // SYS exception with a same-cycle mtc0 EPC that must be dropped
    bus.wb_mtc0   = 1'b1;
    bus.cp0_addr  = CP0_EPC;
    bus.cp0_wdata = 32'hFFFFFFFF;
    commit_exc(EXC_SYS, 32'hBFC00100, 1'b0, 1'b0, 32'd0);
    check("sys_flush", {31'd0, bus.flush}, 32'd1);
    check("sys_target", bus.flush_target, 32'hBFC00380);
    check("sys_exl", {31'd0, bus.status_exl}, 32'd1);
    rd_check("sys_epc", CP0_EPC, 32'hBFC00100);
    rd_check("sys_cause", CP0_CAUSE, 32'h00000020);
    step();
    check("sys_flush_pulse", {31'd0, bus.flush}, 32'd0);
    commit_eret();
    check("eret1_flush", {31'd0, bus.flush}, 32'd1);
    check("eret1_target", bus.flush_target, 32'hBFC00100);
    check("eret1_exl", {31'd0, bus.status_exl}, 32'd0);
    $display("sys exception + eret sequence checked");

    // Delay-slot ADEL followed back-to-back by a nested OV
    commit_exc(EXC_ADEL, 32'hBFC00204, 1'b1, 1'b1, 32'h00000003);
    check("adel_flush", {31'd0, bus.flush}, 32'd1);
    rd_check("adel_epc", CP0_EPC, 32'hBFC00200);
    rd_check("adel_cause", CP0_CAUSE, 32'h80000010);
    rd_check("adel_badvaddr", CP0_BADVADDR, 32'h00000003);
    commit_exc(EXC_OV, 32'h80001000, 1'b0, 1'b0, 32'd0);
    check("ov_flush_b2b", {31'd0, bus.flush}, 32'd1);
    check("ov_target", bus.flush_target, 32'hBFC00380);
    rd_check("ov_epc_kept", CP0_EPC, 32'hBFC00200);
    rd_check("ov_cause", CP0_CAUSE, 32'h80000030);
    step();
    check("ov_flush_end", {31'd0, bus.flush}, 32'd0);
    commit_eret();
    check("eret2_target", bus.flush_target, 32'hBFC00200);
    $display("delay-slot + nested exception sequence checked");

    // Timer interrupt
    mtc0(CP0_STATUS, 32'h00008001);
    mtc0(CP0_COMPARE, 32'd10);
    mtc0(CP0_COUNT, 32'd0);
    repeat (19) @(posedge clock);
    #1;
    rd_check("timer_count9", CP0_COUNT, 32'd9);
    check("timer_pend_early", {31'd0, bus.int_pending}, 32'd0);
    @(posedge clock);
    #1;
    rd_check("timer_count10", CP0_COUNT, 32'd10);
    rd_check("timer_cause_ti", CP0_CAUSE, 32'hC0008030);
    check("timer_pending", {31'd0, bus.int_pending}, 32'd1);
    commit_plain(32'h80000400);
    check("tint_flush", {31'd0, bus.flush}, 32'd1);
    check("tint_target", bus.flush_target, 32'hBFC00380);
    rd_check("tint_cause", CP0_CAUSE, 32'h40008000);
    rd_check("tint_epc", CP0_EPC, 32'h80000400);
    mtc0(CP0_COMPARE, 32'h00001000);
    rd_check("compare_clears_ti", CP0_CAUSE, 32'h00000000);
    mtc0(CP0_STATUS, 32'h00000000);
    $display("timer interrupt sequence checked");

    // Hardware interrupt beats a same-cycle RI exception
    mtc0(CP0_STATUS, 32'h00000401);
    bus.hw_int = 6'b000001;
    step();
    step();
    check("hw_pending", {31'd0, bus.int_pending}, 32'd1);
    commit_exc(EXC_RI, 32'h80000800, 1'b0, 1'b1, 32'h0000AAAA);
    check("hw_flush", {31'd0, bus.flush}, 32'd1);
    rd_check("hw_cause", CP0_CAUSE, 32'h00000400);
    rd_check("hw_badvaddr_kept", CP0_BADVADDR, 32'h00000003);
    rd_check("hw_epc", CP0_EPC, 32'h80000800);
    bus.hw_int = 6'd0;
    mtc0(CP0_STATUS, 32'h00000000);
    $display("interrupt-vs-exception priority sequence checked");

    // Count write on divider terminal count, then wrap, then divider clear
    mtc0(CP0_COUNT, 32'd0);
    step();
    mtc0(CP0_COUNT, 32'hFFFFFFFF);
    rd_check("wrap_write_wins", CP0_COUNT, 32'hFFFFFFFF);
    step();
    rd_check("wrap_hold", CP0_COUNT, 32'hFFFFFFFF);
    step();
    rd_check("wrap_zero", CP0_COUNT, 32'h00000000);
    mtc0(CP0_COUNT, 32'h00000050);
    step();
    rd_check("div_cleared", CP0_COUNT, 32'h00000050);
    step();
    rd_check("div_tick", CP0_COUNT, 32'h00000051);
    $display("count wrap / divider sequence checked");

    // Reset in the same cycle as a commit cancels the pending flush
    bus.wb_valid     = 1'b1;
    bus.wb_exception = 1'b1;
    bus.wb_exc_code  = EXC_BP;
    bus.wb_pc        = 32'h80002000;
    reset            = 1'b1;
    step();
    idle_inputs();
    check("midrst_flush", {31'd0, bus.flush}, 32'd0);
    check("midrst_target", bus.flush_target, 32'd0);
    check("midrst_exl", {31'd0, bus.status_exl}, 32'd0);
    rd_check("midrst_status", CP0_STATUS, 32'h00400000);
    rd_check("midrst_epc", CP0_EPC, 32'h00000000);
    rd_check("midrst_count", CP0_COUNT, 32'h00000000);
    reset = 1'b0;
    step();
    $display("mid-operation reset checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
